// File: rtl/ptw_dmem_responder.sv
// PTE memory responder for the page-table walker dmem port: a backdoor-loaded
// 64-bit PTE store answering reads with data or a nack after a fixed latency.
module ptw_dmem_responder #(
  parameter int                DEPTH      = 512,
  parameter int                ADDR_W     = 40,
  parameter logic [ADDR_W-1:0] BASE_ADDR  = '0,
  parameter int                LATENCY    = 2,
  parameter int                NACK_EVERY = 0
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     req_valid_i,
  input  logic [ADDR_W-1:0]        req_addr_i,
  input  logic [4:0]               req_cmd_i,
  input  logic [3:0]               req_typ_i,
  input  logic                     req_phys_i,
  input  logic                     req_kill_i,
  input  logic [63:0]              req_data_i,
  output logic                     dmem_ready_o,
  output logic                     resp_valid_o,
  output logic                     resp_nack_o,
  output logic [63:0]              resp_data_o,
  input  logic                     wr_en_i,
  input  logic [$clog2(DEPTH)-1:0] wr_idx_i,
  input  logic [63:0]              wr_data_i,
  output logic [31:0]              req_cnt_o,
  output logic [31:0]              nack_cnt_o
);

  localparam int                IDX_W    = $clog2(DEPTH);
  localparam logic [ADDR_W-1:0] DEPTH_A  = ADDR_W'(DEPTH);
  localparam logic [3:0]        LAT_LOAD = 4'((LATENCY > 1) ? (LATENCY - 2) : 0);
  localparam logic [31:0]       INJ_LAST = 32'((NACK_EVERY > 0) ? (NACK_EVERY - 1) : 0);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_e;

  state_e            state_q, state_d;
  logic [3:0]        lat_q, lat_d;
  logic              nack_q, nack_d;
  logic [63:0]       data_q, data_d;
  logic [31:0]       req_cnt_q, req_cnt_d;
  logic [31:0]       nack_cnt_q, nack_cnt_d;
  logic [31:0]       inj_q, inj_d;
  logic [63:0]       mem_q [DEPTH];

  logic              accept;
  logic [ADDR_W-1:0] offs;
  logic [ADDR_W-1:0] word;
  logic              bad_req;
  logic              inj_fire;
  logic              nack_now;
  logic              unused_req_data;

  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

  assign accept          = req_valid_i && dmem_ready_o && !req_kill_i;
  assign offs            = req_addr_i - BASE_ADDR;
  assign word            = offs >> 3;
  assign inj_fire        = (NACK_EVERY > 0) && (inj_q == INJ_LAST);
  assign bad_req         = (req_addr_i < BASE_ADDR) || (word >= DEPTH_A) ||
                           (req_addr_i[2:0] != 3'd0) || (req_cmd_i != 5'd0) ||
                           (req_typ_i != 4'b0011) || !req_phys_i;
  assign nack_now        = bad_req || inj_fire;
  assign unused_req_data = ^req_data_i;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= S_IDLE;
      lat_q      <= 4'd0;
      req_cnt_q  <= 32'd0;
      nack_cnt_q <= 32'd0;
      inj_q      <= 32'd0;
    end else begin
      state_q    <= state_d;
      lat_q      <= lat_d;
      req_cnt_q  <= req_cnt_d;
      nack_cnt_q <= nack_cnt_d;
      inj_q      <= inj_d;
    end
  end

  // Response payload is only observed while in S_RESP, so it needs no reset.
  always_ff @(posedge clk_i) begin
    nack_q <= nack_d;
    data_q <= data_d;
  end

  // Store has no reset; the read snapshot above sees the pre-write value.
  always_ff @(posedge clk_i) begin
    if (wr_en_i) mem_q[wr_idx_i] <= wr_data_i;
  end

  always_comb begin
    state_d = state_q;
    lat_d   = lat_q;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          if (LATENCY == 1) begin
            state_d = S_RESP;
          end else begin
            state_d = S_WAIT;
            lat_d   = LAT_LOAD;
          end
        end
      end
      S_WAIT: begin
        if (lat_q == 4'd0) state_d = S_RESP;
        else               lat_d   = lat_q - 4'd1;
      end
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    nack_d     = nack_q;
    data_d     = data_q;
    req_cnt_d  = req_cnt_q;
    nack_cnt_d = nack_cnt_q;
    inj_d      = inj_q;
    if (accept) begin
      nack_d    = nack_now;
      data_d    = nack_now ? 64'd0 : mem_q[word[IDX_W-1:0]];
      req_cnt_d = sat_inc(req_cnt_q);
      if (NACK_EVERY > 0) inj_d = inj_fire ? 32'd0 : inj_q + 32'd1;
    end
    // Nack count becomes visible in the response cycle itself.
    if ((state_d == S_RESP) && nack_d) nack_cnt_d = sat_inc(nack_cnt_q);
  end

  always_comb begin
    dmem_ready_o = (state_q == S_IDLE);
    resp_valid_o = (state_q == S_RESP) && !nack_q;
    resp_nack_o  = (state_q == S_RESP) && nack_q;
    resp_data_o  = ((state_q == S_RESP) && !nack_q) ? data_q : 64'd0;
  end

  assign req_cnt_o  = req_cnt_q;
  assign nack_cnt_o = nack_cnt_q;

endmodule

// File: tb/tb_ptw_dmem_responder.sv
// Bench for ptw_dmem_responder: two instances (LATENCY=2 without injection,
// LATENCY=1 with every-3rd nack) checked against a transaction-level model.
module tb_ptw_dmem_responder;

  localparam logic [39:0] BASE = 40'd0;

  logic        clk = 1'b0;
  logic        rst [2];
  logic        rv  [2];
  logic [39:0] ra  [2];
  logic [4:0]  rc  [2];
  logic [3:0]  rt  [2];
  logic        rp  [2];
  logic        rk  [2];
  logic [63:0] rd  [2];
  logic        rdy [2];
  logic        vo  [2];
  logic        no  [2];
  logic [63:0] dout[2];
  logic        we  [2];
  logic [8:0]  wi  [2];
  logic [63:0] wd  [2];
  logic [31:0] rcnt[2];
  logic [31:0] ncnt[2];

  logic [63:0] mm [2][512];
  int unsigned m_req [2];
  int unsigned m_nack[2];
  int unsigned m_acc [2];
  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 2; g++) begin : g_dut
    ptw_dmem_responder #(
      .DEPTH(512), .ADDR_W(40), .BASE_ADDR(40'd0),
      .LATENCY(g == 0 ? 2 : 1), .NACK_EVERY(g == 0 ? 0 : 3)
    ) u_dut (
      .clk_i(clk), .rst_i(rst[g]),
      .req_valid_i(rv[g]), .req_addr_i(ra[g]), .req_cmd_i(rc[g]),
      .req_typ_i(rt[g]), .req_phys_i(rp[g]), .req_kill_i(rk[g]),
      .req_data_i(rd[g]), .dmem_ready_o(rdy[g]), .resp_valid_o(vo[g]),
      .resp_nack_o(no[g]), .resp_data_o(dout[g]), .wr_en_i(we[g]),
      .wr_idx_i(wi[g]), .wr_data_i(wd[g]), .req_cnt_o(rcnt[g]),
      .nack_cnt_o(ncnt[g])
    );
  end

  function automatic int lat_of(input int d);
    return (d == 0) ? 2 : 1;
  endfunction

  function automatic int ne_of(input int d);
    return (d == 0) ? 0 : 3;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference: the k-th accepted request (1-based) is injected when k is a multiple of N.
  task automatic model_accept(input int d, input logic [39:0] a, input logic [4:0] c,
                              input logic [3:0] t, input logic p,
                              output logic en, output logic [63:0] ed);
    logic inj;
    m_acc[d]++;
    m_req[d]++;
    inj = (ne_of(d) > 0) && (m_acc[d] % ne_of(d) == 0);
    en  = (a < BASE) || ((a - BASE) / 8 >= 512) || (a % 8 != 0) ||
          (c != 5'd0) || (t != 4'd3) || !p || inj;
    ed  = en ? 64'd0 : mm[d][(a - BASE) / 8];
  endtask

  task automatic drive_idle(input int d);
    rv[d] = 1'b0; rk[d] = 1'b0; ra[d] = '0; rc[d] = 5'd0; rt[d] = 4'd3;
    rp[d] = 1'b1; rd[d] = {$urandom, $urandom}; we[d] = 1'b0; wi[d] = '0; wd[d] = '0;
  endtask

  task automatic bd_write(input int d, input logic [8:0] idx, input logic [63:0] dat);
    @(negedge clk);
    we[d] = 1'b1; wi[d] = idx; wd[d] = dat;
    @(negedge clk);
    we[d] = 1'b0;
    mm[d][idx] = dat;
  endtask

  // wmode: 0 none, 1 write same word in acceptance cycle, 2 write it one cycle later
  task automatic txn(input int d, input logic [39:0] a, input logic [4:0] c,
                     input logic [3:0] t, input logic p, input int wmode,
                     input logic [63:0] wdat);
    int          lat;
    logic        en;
    logic [63:0] ed;
    logic [8:0]  widx;
    lat  = lat_of(d);
    widx = a[11:3];
    @(negedge clk);
    chk("ready_before", {63'd0, rdy[d]}, 64'd1);
    rv[d] = 1'b1; ra[d] = a; rc[d] = c; rt[d] = t; rp[d] = p; rk[d] = 1'b0;
    rd[d] = {$urandom, $urandom};
    model_accept(d, a, c, t, p, en, ed);
    if (wmode == 1) begin we[d] = 1'b1; wi[d] = widx; wd[d] = wdat; end
    @(negedge clk);
    rv[d] = 1'b0; we[d] = 1'b0;
    if (wmode == 1) mm[d][widx] = wdat;
    if (wmode == 2) begin we[d] = 1'b1; wi[d] = widx; wd[d] = wdat; end
    for (int i = 1; i <= lat; i++) begin
      if (i > 1) begin
        @(negedge clk);
        we[d] = 1'b0;
      end
      chk("ready_busy", {63'd0, rdy[d]}, 64'd0);
      if (i < lat) begin
        chk("early_resp", {62'd0, vo[d], no[d]}, 64'd0);
      end else begin
        chk("resp_valid", {63'd0, vo[d]}, {63'd0, !en});
        chk("resp_nack", {63'd0, no[d]}, {63'd0, en});
        chk("resp_data", dout[d], ed);
      end
    end
    @(negedge clk);
    we[d] = 1'b0;
    if (wmode == 2) mm[d][widx] = wdat;
    if (en) m_nack[d]++;
    chk("ready_after", {63'd0, rdy[d]}, 64'd1);
    chk("resp_cleared", {62'd0, vo[d], no[d]}, 64'd0);
    chk("req_cnt", {32'd0, rcnt[d]}, {32'd0, m_req[d]});
    chk("nack_cnt", {32'd0, ncnt[d]}, {32'd0, m_nack[d]});
  endtask

  task automatic rd_word(input int d, input int idx);
    txn(d, BASE + 40'(idx) * 40'd8, 5'd0, 4'd3, 1'b1, 0, 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    for (int d = 0; d < 2; d++) begin
      drive_idle(d);
      rst[d] = 1'b1;
      m_req[d] = 0; m_nack[d] = 0; m_acc[d] = 0;
    end
    repeat (3) @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      chk("rst_ready", {63'd0, rdy[d]}, 64'd1);
      chk("rst_resp", {62'd0, vo[d], no[d]}, 64'd0);
      chk("rst_data", dout[d], 64'd0);
      chk("rst_req_cnt", {32'd0, rcnt[d]}, 64'd0);
      chk("rst_nack_cnt", {32'd0, ncnt[d]}, 64'd0);
      rst[d] = 1'b0;
    end
    for (int d = 0; d < 2; d++)
      for (int i = 0; i < 16; i++) bd_write(d, 9'(i), {$urandom, $urandom});

    // Basic read of word 5, then the illegal-request nacks.
    bd_write(0, 9'd5, 64'h0000_0000_2000_0401);
    txn(0, BASE + 40'h28, 5'd0, 4'd3, 1'b1, 0, 64'd0);
    chk("first_req_cnt", {32'd0, rcnt[0]}, 64'd1);
    txn(0, BASE + 40'h2C, 5'd0, 4'd3, 1'b1, 0, 64'd0);
    txn(0, BASE + 40'h28, 5'b01010, 4'd3, 1'b1, 0, 64'd0);
    txn(0, BASE + 40'h28, 5'd0, 4'd3, 1'b0, 0, 64'd0);
    txn(0, BASE + 40'd512 * 40'd8, 5'd0, 4'd3, 1'b1, 0, 64'd0);
    txn(0, BASE + 40'h28, 5'd0, 4'd2, 1'b1, 0, 64'd0);
    chk("nack_cnt_5", {32'd0, ncnt[0]}, 64'd5);

    // Read-before-write in the acceptance cycle, then a write during WAIT.
    bd_write(0, 9'd7, 64'h1111_2222_3333_4444);
    txn(0, BASE + 40'h38, 5'd0, 4'd3, 1'b1, 1, 64'hDEAD);
    rd_word(0, 7);
    chk("dead_data_seen", {63'd0, vo[0]}, 64'd0);
    txn(0, BASE + 40'h38, 5'd0, 4'd3, 1'b1, 2, 64'hBEEF);
    rd_word(0, 7);

    // Kill: no acceptance, nothing changes.
    @(negedge clk);
    rv[0] = 1'b1; rk[0] = 1'b1; ra[0] = BASE + 40'h28;
    @(negedge clk);
    rv[0] = 1'b0; rk[0] = 1'b0;
    chk("kill_ready", {63'd0, rdy[0]}, 64'd1);
    chk("kill_req_cnt", {32'd0, rcnt[0]}, {32'd0, m_req[0]});
    repeat (3) begin
      @(negedge clk);
      chk("kill_no_resp", {62'd0, vo[0], no[0]}, 64'd0);
    end

    // Reset one cycle after acceptance aborts the request.
    @(negedge clk);
    rv[0] = 1'b1; ra[0] = BASE + 40'h28;
    @(negedge clk);
    rv[0] = 1'b0;
    rst[0] = 1'b1;
    #1;
    chk("abort_ready", {63'd0, rdy[0]}, 64'd1);
    chk("abort_resp", {62'd0, vo[0], no[0]}, 64'd0);
    chk("abort_req_cnt", {32'd0, rcnt[0]}, 64'd0);
    chk("abort_nack_cnt", {32'd0, ncnt[0]}, 64'd0);
    m_req[0] = 0; m_nack[0] = 0; m_acc[0] = 0;
    @(negedge clk);
    rst[0] = 1'b0;
    repeat (4) begin
      @(negedge clk);
      chk("abort_silent", {62'd0, vo[0], no[0]}, 64'd0);
      chk("abort_idle", {63'd0, rdy[0]}, 64'd1);
    end
    rd_word(0, 5);
    chk("retained_word5", {63'd0, vo[0]}, 64'd0);

    // Injection: six legal reads, 3rd and 6th nacked.
    for (int i = 0; i < 6; i++) rd_word(1, i);
    chk("inj_req_cnt", {32'd0, rcnt[1]}, 64'd6);
    chk("inj_nack_cnt", {32'd0, ncnt[1]}, 64'd2);

    // LATENCY=1 with valid held: accept every other cycle.
    begin
      logic        en;
      logic [63:0] ed;
      en = 1'b0; ed = '0;
      @(negedge clk);
      rv[1] = 1'b1; ra[1] = BASE + 40'h18;
      for (int k = 0; k < 6; k++) begin
        chk("b2b_ready", {63'd0, rdy[1]}, {63'd0, (k % 2 == 0)});
        if (k % 2 == 0) begin
          model_accept(1, ra[1], rc[1], rt[1], rp[1], en, ed);
        end else begin
          chk("b2b_valid", {63'd0, vo[1]}, {63'd0, !en});
          chk("b2b_nack", {63'd0, no[1]}, {63'd0, en});
          chk("b2b_data", dout[1], ed);
          if (en) m_nack[1]++;
        end
        @(negedge clk);
      end
      rv[1] = 1'b0;
      chk("b2b_req_cnt", {32'd0, rcnt[1]}, {32'd0, m_req[1]});
      chk("b2b_nack_cnt", {32'd0, ncnt[1]}, {32'd0, m_nack[1]});
    end

    // Randomized traffic on both instances.
    for (int d = 0; d < 2; d++) begin
      for (int n = 0; n < 40; n++) begin
        int          kind;
        logic [39:0] a;
        logic [4:0]  c;
        logic [3:0]  t;
        logic        p;
        kind = $urandom_range(0, 9);
        a = BASE + 40'($urandom_range(0, 15)) * 40'd8;
        c = 5'd0; t = 4'd3; p = 1'b1;
        case (kind)
          0: a = a + 40'($urandom_range(1, 7));
          1: a = BASE + 40'($urandom_range(512, 1023)) * 40'd8;
          2: c = 5'($urandom_range(1, 31));
          3: t = 4'($urandom_range(4, 15));
          4: p = 1'b0;
          default: ;
        endcase
        repeat ($urandom_range(0, 2)) @(negedge clk);
        txn(d, a, c, t, p, (kind == 1) ? 0 : int'($urandom_range(0, 2)),
            {$urandom, $urandom});
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
